// File: rtl/axis_rx_frame_fifo.sv
// Store-and-forward receive frame buffer: commits good frames, drops bad or overflowing
// frames, and replays committed frames through a ready/valid master with a FWFT output.
module axis_rx_frame_fifo #(
  parameter int unsigned P_ADDR_WIDTH = 9,
  parameter int unsigned P_CNT_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            s_tdata_i,
  input  logic [1:0]             s_tvldb_i,
  input  logic                   s_tvalid_i,
  input  logic                   s_tlast_i,
  input  logic                   s_tuser_i,
  output logic [31:0]            m_tdata_o,
  output logic [1:0]             m_tvldb_o,
  output logic                   m_tvalid_o,
  output logic                   m_tlast_o,
  input  logic                   m_tready_i,
  output logic [P_CNT_WIDTH-1:0] good_frames_o,
  output logic [P_CNT_WIDTH-1:0] bad_frames_o,
  output logic [P_CNT_WIDTH-1:0] ovf_frames_o,
  output logic                   drop_o
);

  localparam int unsigned PW    = P_ADDR_WIDTH + 1;
  localparam int unsigned BW    = 35;
  localparam int unsigned DEPTH = 1 << P_ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DISCARD} wr_state_e;

  wr_state_e              state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [P_CNT_WIDTH-1:0] good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
  logic                   drop_q, drop_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [BW-1:0]          m_beat_q, m_beat_d;
  logic [BW-1:0]          rd_data_q;
  logic [BW-1:0]          mem_q [DEPTH];
  logic [PW-1:0]          used;
  logic                   full, wr_en, rd_issue, out_ld;

  // Occupancy counts beats still in RAM; beats already read into the pipeline free space.
  assign used = wr_ptr_q - rd_ptr_q;
  assign full = (used == PW'(DEPTH));

  // Write-side frame FSM with commit / rewind of the speculative write pointer.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    good_d       = good_q;
    bad_d        = bad_q;
    ovf_d        = ovf_q;
    drop_d       = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (s_tvalid_i) begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            state_d  = ST_WRITE;
            if (s_tlast_i) begin
              state_d = ST_IDLE;
              if (s_tuser_i) begin
                wr_ptr_d = commit_ptr_q;
                bad_d    = bad_q + P_CNT_WIDTH'(1);
                drop_d   = 1'b1;
              end else begin
                commit_ptr_d = wr_ptr_q + PW'(1);
                good_d       = good_q + P_CNT_WIDTH'(1);
              end
            end
          end else begin
            wr_ptr_d = commit_ptr_q;
            ovf_d    = ovf_q + P_CNT_WIDTH'(1);
            drop_d   = 1'b1;
            state_d  = s_tlast_i ? ST_IDLE : ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (s_tvalid_i && s_tlast_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read side: RAM read register feeding the output register, one beat per cycle.
  always_comb begin
    out_ld     = rd_vld_q && (!m_tvalid_q || m_tready_i);
    rd_issue   = (rd_ptr_q != commit_ptr_q) && (!rd_vld_q || out_ld);
    rd_ptr_d   = rd_issue ? rd_ptr_q + PW'(1) : rd_ptr_q;
    rd_vld_d   = rd_issue ? 1'b1 : (out_ld ? 1'b0 : rd_vld_q);
    m_beat_d   = out_ld ? rd_data_q : m_beat_q;
    m_tvalid_d = out_ld ? 1'b1 : (m_tready_i ? 1'b0 : m_tvalid_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      ovf_q        <= '0;
      drop_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_beat_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      rd_vld_q     <= rd_vld_d;
      m_tvalid_q   <= m_tvalid_d;
      m_beat_q     <= m_beat_d;
    end
  end

  // Storage array and its registered read port; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[P_ADDR_WIDTH-1:0]] <= {s_tlast_i, s_tvldb_i, s_tdata_i};
    if (rd_issue) rd_data_q <= mem_q[rd_ptr_q[P_ADDR_WIDTH-1:0]];
  end

  assign m_tlast_o     = m_beat_q[34];
  assign m_tvldb_o     = m_beat_q[33:32];
  assign m_tdata_o     = m_beat_q[31:0];
  assign m_tvalid_o    = m_tvalid_q;
  assign good_frames_o = good_q;
  assign bad_frames_o  = bad_q;
  assign ovf_frames_o  = ovf_q;
  assign drop_o        = drop_q;

endmodule

// File: tb/tb_axis_rx_frame_fifo.sv
// Bench for axis_rx_frame_fifo: a frame-level model (expected beat queue and counters)
// checked every cycle, plus literal expectations at each scenario boundary.
module tb_axis_rx_frame_fifo;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 32;
  localparam int GOOD = 0;
  localparam int BAD  = 1;
  localparam int OVF  = 2;

  logic          clk, rst;
  logic [31:0]   s_tdata;
  logic [1:0]    s_tvldb;
  logic          s_tvalid, s_tlast, s_tuser;
  logic [31:0]   m_tdata;
  logic [1:0]    m_tvldb;
  logic          m_tvalid, m_tlast, m_tready;
  logic [CW-1:0] good_frames, bad_frames, ovf_frames;
  logic          drop;

  axis_rx_frame_fifo #(.P_ADDR_WIDTH(AW), .P_CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_tdata_i(s_tdata), .s_tvldb_i(s_tvldb), .s_tvalid_i(s_tvalid),
    .s_tlast_i(s_tlast), .s_tuser_i(s_tuser),
    .m_tdata_o(m_tdata), .m_tvldb_o(m_tvldb), .m_tvalid_o(m_tvalid),
    .m_tlast_o(m_tlast), .m_tready_i(m_tready),
    .good_frames_o(good_frames), .bad_frames_o(bad_frames),
    .ovf_frames_o(ovf_frames), .drop_o(drop)
  );

  // Frame-level model: committed beats in order, plus expected statistics.
  logic [34:0] exp_q[$];
  int exp_good, exp_bad, exp_ovf, exp_drops, seen_drops;
  int n_tests, n_fail;
  int rdy_mode;
  bit held_vld;
  logic [34:0] held_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_good = 0; exp_bad = 0; exp_ovf = 0; exp_drops = 0; seen_drops = 0;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready pattern: 0 = stalled, 1 = always ready, 2 = toggle every cycle.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = ~m_tready;
      endcase
    end
  end

  // Per-cycle compare: counters, drop pulses, output beats and stall stability.
  initial begin
    logic [34:0] beat;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_vld = 1'b0;
      end else begin
        beat = {m_tlast, m_tvldb, m_tdata};
        if (drop) seen_drops++;
        check("good_cnt", good_frames, exp_good);
        check("bad_cnt", bad_frames, exp_bad);
        check("ovf_cnt", ovf_frames, exp_ovf);
        check("drop_pulses", seen_drops, exp_drops);
        if (held_vld) check("stall_hold", {m_tvalid, beat}, {1'b1, held_beat});
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) check("spurious_beat", m_tvalid, 0);
          else check("out_beat", beat, exp_q.pop_front());
        end
        held_vld  = m_tvalid && !m_tready;
        held_beat = beat;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the model updates right after the edge that samples the deciding beat.
  task automatic send_frame(input int id, input int nb, input logic [1:0] vldb,
                            input int outcome, input int ovf_at);
    logic [34:0] beats[$];
    logic last;
    for (int i = 0; i < nb; i++) begin
      last     = (i == nb - 1);
      s_tvalid = 1'b1;
      s_tlast  = last;
      s_tdata  = {id[15:0], i[15:0]};
      s_tvldb  = last ? vldb : 2'(i);
      s_tuser  = last && (outcome == BAD);
      beats.push_back({last, s_tvldb, s_tdata});
      @(posedge clk); #1;
      if (outcome == OVF && i == ovf_at) begin exp_ovf++; exp_drops++; end
      if (last && outcome == BAD) begin exp_bad++; exp_drops++; end
      if (last && outcome == GOOD) begin
        exp_good++;
        foreach (beats[k]) exp_q.push_back(beats[k]);
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (exp_q.size() == 0 && !m_tvalid) break;
      @(posedge clk); #1;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_idle", m_tvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; rdy_mode = 0; held_vld = 1'b0;
    model_clear();
    s_tdata = '0; s_tvldb = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tvldb", m_tvldb, 0);
    check("rst_good", good_frames, 0);
    check("rst_drop", drop, 0);
    rst = 1'b0; rdy_mode = 1;
    idle(3);

    // Single 4-beat good frame: first beat on m_* two cycles after the tlast edge.
    send_frame(1, 4, 2'd3, GOOD, 0);
    @(negedge clk); check("lat_cyc0", m_tvalid, 0);
    @(negedge clk); check("lat_cyc1", m_tvalid, 0);
    @(negedge clk); check("lat_cyc2", m_tvalid, 1);
    check("first_data", m_tdata, 32'h0001_0000);
    @(posedge clk); #1;
    wait_drain(50);
    check("t1_good", good_frames, 1);

    // Bad 3-beat frame followed by a good 2-beat frame.
    send_frame(2, 3, 2'd1, BAD, 0);
    send_frame(3, 2, 2'd2, GOOD, 0);
    wait_drain(50);
    check("t2_bad", bad_frames, 1);
    check("t2_good", good_frames, 2);
    check("t2_drops", seen_drops, 1);

    // Stalled output, frame larger than the buffer, then a good 4-beat frame.
    rdy_mode = 0; idle(2);
    send_frame(4, DEPTH + 4, 2'd3, OVF, DEPTH);
    idle(5);
    check("t3_no_out", m_tvalid, 0);
    check("t3_ovf", ovf_frames, 1);
    send_frame(5, 4, 2'd1, GOOD, 0);
    idle(4);
    check("t3_held_first", m_tdata, 32'h0005_0000);
    rdy_mode = 1;
    wait_drain(50);
    check("t3_good", good_frames, 3);

    // Back-to-back 64-byte frames against a toggling ready.
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) send_frame(6 + f, 16, 2'd3, GOOD, 0);
    wait_drain(400);
    check("t4_good", good_frames, 7);
    check("t4_ovf", ovf_frames, 1);

    // Exactly full with one committed frame; next beat on the very next cycle overflows.
    rdy_mode = 0; idle(3);
    send_frame(10, DEPTH, 2'd3, GOOD, 0);
    send_frame(11, 1, 2'd0, OVF, 0);
    idle(4);
    check("t5_ovf", ovf_frames, 2);
    check("t5_good", good_frames, 8);
    rdy_mode = 1;
    wait_drain(200);

    // Reset while a frame is held on the output and another is mid-write.
    rdy_mode = 0; idle(2);
    send_frame(12, 4, 2'd3, GOOD, 0);
    idle(4);
    check("t6_pre_vld", m_tvalid, 1);
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tuser = 1'b0;
      s_tdata = {16'd13, 16'(i)}; s_tvldb = 2'(i);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    rst = 1'b1;
    model_clear();
    #1;
    check("t6_rst_vld", m_tvalid, 0);
    check("t6_rst_good", good_frames, 0);
    check("t6_rst_ovf", ovf_frames, 0);
    check("t6_rst_bad", bad_frames, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    send_frame(14, 2, 2'd1, GOOD, 0);
    rdy_mode = 1;
    wait_drain(50);
    check("t6_good", good_frames, 1);
    check("t6_drops", seen_drops, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
